// File: rtl/sc_register_bank.sv
// sc_register_bank: datapath register file.
//   Registers 1..13 (g1-g7, PC=8, Temp0-3=9..12, IR=13), g0 hardwired zero.
//   Ports:
//     SC_REGBANK_CLOCK_50           rising-edge clock
//     SC_REGBANK_RESET_InLow        async active-low reset
//     SC_REGBANK_Load_InBUS         active-low one-hot load enables
//     SC_REGBANK_DataC_InBUS        write data
//     SC_REGBANK_PCinc_InHigh       PC += PC_STEP (load has priority)
//     SC_REGBANK_SelectA/B_InBUS    combinational read selects
//     SC_REGBANK_DataA/B_OutBUS     read data (0 for codes 0, 14, 15)
//     SC_REGBANK_IR_OutBUS          IR contents
//     SC_REGBANK_LoadError_OutHigh  sticky illegal-load-pattern flag

// One storage cell: load beats increment; increment only used by the PC.
module sc_regbank_cell #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter int          STEP    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_VAL;
    else if (ld)  q <= d;
    else if (inc) q <= q + W'(STEP);   // wraps modulo 2^W
  end
endmodule

module sc_register_bank #(
  parameter int          DATAWIDTH_BUS               = 32,
  parameter int          DATAWIDTH_DECODER_SELECTION = 4,
  parameter int          DATAWIDTH_DECODER_OUT       = 16,
  parameter logic [31:0] PC_RESET_VALUE              = 32'h0000_0000,
  parameter int          PC_STEP                     = 4
) (
  input  logic                                   SC_REGBANK_CLOCK_50,
  input  logic                                   SC_REGBANK_RESET_InLow,
  input  logic [DATAWIDTH_DECODER_OUT-1:0]       SC_REGBANK_Load_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_DataC_InBUS,
  input  logic                                   SC_REGBANK_PCinc_InHigh,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_REGBANK_SelectA_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_REGBANK_SelectB_InBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_DataA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_DataB_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_IR_OutBUS,
  output logic                                   SC_REGBANK_LoadError_OutHigh
);
  localparam int NUM_REGS = 14;                          // g0..IR
  localparam int NUM_CODES = 2 ** DATAWIDTH_DECODER_SELECTION;
  localparam int PC_IDX = 8;
  localparam int IR_IDX = 13;

  logic                                   clk, rst_n;
  logic [DATAWIDTH_DECODER_OUT-1:0]       load;
  logic                                   idle, legal;
  logic [NUM_REGS-1:1]                    load_en;
  logic [NUM_CODES-1:0][DATAWIDTH_BUS-1:0] regs;
  logic                                   load_err;

  assign clk   = SC_REGBANK_CLOCK_50;
  assign rst_n = SC_REGBANK_RESET_InLow;
  assign load  = SC_REGBANK_Load_InBUS;

  // Legal: all ones, or exactly one zero in the register field with the
  // unused top bits held high. Anything else blocks every load that edge.
  assign idle  = &load;
  assign legal = idle |
                 ((&load[DATAWIDTH_DECODER_OUT-1:NUM_REGS]) &&
                  $onehot(~load[NUM_REGS-1:0]));
  assign load_en = ~load[NUM_REGS-1:1] & {(NUM_REGS-1){legal}};

  // Code 0 and codes past IR read as zero.
  assign regs[0] = '0;
  genvar i;
  generate
    for (i = NUM_REGS; i < NUM_CODES; i++) begin : g_zero
      assign regs[i] = '0;
    end
    for (i = 1; i < NUM_REGS; i++) begin : g_reg
      sc_regbank_cell #(
        .W       (DATAWIDTH_BUS),
        .RST_VAL ((i == PC_IDX) ? DATAWIDTH_BUS'(PC_RESET_VALUE) : '0),
        .STEP    (PC_STEP)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (load_en[i]),
        .inc   ((i == PC_IDX) ? SC_REGBANK_PCinc_InHigh : 1'b0),
        .d     (SC_REGBANK_DataC_InBUS),
        .q     (regs[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      load_err <= 1'b0;
    else if (!legal) load_err <= 1'b1;
  end

  assign SC_REGBANK_DataA_OutBUS      = regs[SC_REGBANK_SelectA_InBUS];
  assign SC_REGBANK_DataB_OutBUS      = regs[SC_REGBANK_SelectB_InBUS];
  assign SC_REGBANK_IR_OutBUS         = regs[IR_IDX];
  assign SC_REGBANK_LoadError_OutHigh = load_err;
endmodule

// File: tb/tb_sc_register_bank.sv
module tb_sc_register_bank;
  localparam logic [31:0] PC_RST = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] load;
  logic [31:0] data_c;
  logic        pc_inc;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] data_a, data_b, ir;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_register_bank #(.PC_RESET_VALUE(PC_RST)) dut (
    .SC_REGBANK_CLOCK_50          (clk),
    .SC_REGBANK_RESET_InLow       (rst_n),
    .SC_REGBANK_Load_InBUS        (load),
    .SC_REGBANK_DataC_InBUS       (data_c),
    .SC_REGBANK_PCinc_InHigh      (pc_inc),
    .SC_REGBANK_SelectA_InBUS     (sel_a),
    .SC_REGBANK_SelectB_InBUS     (sel_b),
    .SC_REGBANK_DataA_OutBUS      (data_a),
    .SC_REGBANK_DataB_OutBUS      (data_b),
    .SC_REGBANK_IR_OutBUS         (ir),
    .SC_REGBANK_LoadError_OutHigh (err)
  );

  // Advance one rising edge; returns 1ns after it (away from the edge).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    load   = ~(16'h0001 << idx);
    data_c = val;
    tick();
    load   = 16'hFFFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 16'h0000; data_c = 32'hDEAD_BEEF; pc_inc = 1'b1;
    sel_a = 4'd0; sel_b = 4'd0;
    #3;  // before the first clock edge
    for (int c = 0; c < 16; c++) begin
      logic [31:0] exp_v;
      sel_a = c[3:0]; sel_b = c[3:0]; #1;
      exp_v = (c == 8) ? PC_RST : 32'h0;
      checks++;
      if (data_a !== exp_v || data_b !== exp_v) begin
        errors++;
        $display("FAIL reset_read code %0d: A=%h B=%h expected %h", c, data_a, data_b, exp_v);
      end
    end
    checks++;
    if (err !== 1'b0 || ir !== 32'h0) begin
      errors++;
      $display("FAIL reset_flags: err=%b ir=%h expected 0/0", err, ir);
    end
    tick(); tick();  // edges while in reset must not disturb anything
    sel_a = 4'd8; #1;
    checks++;
    if (data_a !== PC_RST || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: pc=%h err=%b expected %h/0", data_a, err, PC_RST);
    end
    @(negedge clk);
    load = 16'hFFFF; pc_inc = 1'b0; data_c = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_writes();
    for (int i = 1; i <= 13; i++) write_reg(i, 32'hA5A5_0000 + i);
    for (int i = 1; i <= 13; i++) begin
      sel_a = i[3:0]; sel_b = i[3:0]; #1;
      checks++;
      if (data_a !== 32'hA5A5_0000 + i || data_b !== 32'hA5A5_0000 + i) begin
        errors++;
        $display("FAIL single_write reg %0d: A=%h B=%h expected %h", i, data_a, data_b, 32'hA5A5_0000 + i);
      end
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] c;
      c = (k == 0) ? 4'd0 : (k == 1) ? 4'd14 : 4'd15;
      sel_a = c; sel_b = c; #1;
      checks++;
      if (data_a !== 32'h0 || data_b !== 32'h0) begin
        errors++;
        $display("FAIL zero_code %0d: A=%h B=%h expected 0", c, data_a, data_b);
      end
    end
    sel_a = 4'd2; sel_b = 4'd11; #1;
    checks++;
    if (data_a !== 32'hA5A5_0002 || data_b !== 32'hA5A5_000B) begin
      errors++;
      $display("FAIL independent_ports: A=%h B=%h expected a5a50002/a5a5000b", data_a, data_b);
    end
    checks++;
    if (ir !== 32'hA5A5_000D || err !== 1'b0) begin
      errors++;
      $display("FAIL ir_out: ir=%h err=%b expected a5a5000d/0", ir, err);
    end
  endtask

  task automatic test_g0();
    write_reg(0, 32'hFFFF_FFFF);
    sel_a = 4'd0; #1;
    checks++;
    if (data_a !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL g0_write: A=%h err=%b expected 0/0", data_a, err);
    end
    for (int i = 1; i <= 13; i++) begin
      sel_b = i[3:0]; #1;
      checks++;
      if (data_b !== 32'hA5A5_0000 + i) begin
        errors++;
        $display("FAIL g0_side_effect reg %0d: got %h expected %h", i, data_b, 32'hA5A5_0000 + i);
      end
    end
  endtask

  task automatic test_pc();
    write_reg(8, 32'h0);
    sel_a = 4'd8;
    pc_inc = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (data_a !== 32'h0000_000C) begin
      errors++;
      $display("FAIL pc_inc3: pc=%h expected 0000000c", data_a);
    end
    load = ~(16'h0001 << 8); data_c = 32'hFFFF_FFFC;
    tick();
    load = 16'hFFFF;
    checks++;
    if (data_a !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL pc_load_priority: pc=%h expected fffffffc", data_a);
    end
    tick();
    pc_inc = 1'b0;
    checks++;
    if (data_a !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h expected 00000000", data_a);
    end
    tick();
    checks++;
    if (data_a !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_hold: pc=%h expected 00000000", data_a);
    end
  endtask

  task automatic test_illegal();
    load = 16'hFFF9; data_c = 32'h1234_5678; pc_inc = 1'b1;
    sel_a = 4'd1; sel_b = 4'd2; #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_before_edge: err=%b expected 0", err);
    end
    tick();
    load = 16'hFFFF; pc_inc = 1'b0;
    checks++;
    if (data_a !== 32'hA5A5_0001 || data_b !== 32'hA5A5_0002 || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_two_zero: g1=%h g2=%h err=%b expected a5a50001/a5a50002/1", data_a, data_b, err);
    end
    sel_a = 4'd8; #1;
    checks++;
    if (data_a !== 32'h0000_0004) begin
      errors++;
      $display("FAIL illegal_pc_inc: pc=%h expected 00000004", data_a);
    end
    write_reg(4, 32'h0000_0077);
    sel_a = 4'd4; #1;
    checks++;
    if (data_a !== 32'h0000_0077 || err !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: g4=%h err=%b expected 00000077/1", data_a, err);
    end
    // Mid-cycle async reset with a write pending clears everything at once.
    load = ~(16'h0001 << 5); data_c = 32'h5555_5555;
    #2 rst_n = 1'b0; #1;
    checks++;
    if (data_a !== 32'h0 || err !== 1'b0 || ir !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: g4=%h err=%b ir=%h expected 0/0/0", data_a, err, ir);
    end
    sel_b = 4'd8; #1;
    checks++;
    if (data_b !== PC_RST) begin
      errors++;
      $display("FAIL async_reset_pc: pc=%h expected %h", data_b, PC_RST);
    end
    @(negedge clk);
    load = 16'hFFFF; rst_n = 1'b1;
    load = 16'h7FFF; data_c = 32'hCAFE_0000; sel_a = 4'd1;
    tick();
    load = 16'hFFFF;
    checks++;
    if (err !== 1'b1 || data_a !== 32'h0) begin
      errors++;
      $display("FAIL illegal_bit15: err=%b g1=%h expected 1/0", err, data_a);
    end
    rst_n = 1'b0; #1; rst_n = 1'b1;
  endtask

  task automatic test_read_during_write();
    write_reg(3, 32'd11);
    load = ~(16'h0001 << 3); data_c = 32'd22; sel_a = 4'd3; sel_b = 4'd3; #1;
    checks++;
    if (data_a !== 32'd11 || data_b !== 32'd11) begin
      errors++;
      $display("FAIL rdw_old: A=%0d B=%0d expected 11", data_a, data_b);
    end
    tick();
    load = 16'hFFFF;
    checks++;
    if (data_a !== 32'd22 || data_b !== 32'd22 || err !== 1'b0) begin
      errors++;
      $display("FAIL rdw_new: A=%0d B=%0d err=%b expected 22/22/0", data_a, data_b, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_writes();
    test_g0();
    test_pc();
    test_illegal();
    test_read_during_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
